// File: rtl/btn_repeat_array_if.sv
`default_nettype none
// ============================================================================
//  Module      : btn_repeat_array_if
//  Description : Bundle of per-channel button levels, auto-repeat enables and
//                the conditioned strobes/levels returned by btn_repeat_array.
//  Ports       : (interface signals, all NUM_CH wide unless noted)
//                noisy_in      raw button levels            (master -> slave)
//                repeat_en_in  per-channel auto-repeat en   (master -> slave)
//                clean_out     debounced levels             (slave -> master)
//                press_out     debounced rising-edge strobe (slave -> master)
//                release_out   debounced falling-edge strobe(slave -> master)
//                move_out      press / repeat strobe        (slave -> master)
//                long_out      held-past-delay level        (slave -> master)
//                any_move_out  1 bit, OR of move_out        (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface btn_repeat_array_if #(
   parameter int NUM_CH = 5
);
   logic [NUM_CH-1:0] noisy_in;
   logic [NUM_CH-1:0] repeat_en_in;
   logic [NUM_CH-1:0] clean_out;
   logic [NUM_CH-1:0] press_out;
   logic [NUM_CH-1:0] release_out;
   logic [NUM_CH-1:0] move_out;
   logic [NUM_CH-1:0] long_out;
   logic              any_move_out;

   modport master (
      output noisy_in, repeat_en_in,
      input  clean_out, press_out, release_out, move_out, long_out, any_move_out
   );

   modport slave (
      input  noisy_in, repeat_en_in,
      output clean_out, press_out, release_out, move_out, long_out, any_move_out
   );
endinterface
`default_nettype wire

// File: rtl/btn_repeat_array.sv
`default_nettype none
// ============================================================================
//  Module      : btn_repeat_array
//  Description : NUM_CH independent button channels. Each channel debounces
//                its raw input over 2**LOG_DEBOUNCE_COUNT cycles, detects
//                debounced edges, and runs a press/delay/repeat FSM that
//                emits move strobes on press, after 2**LOG_DELAY_COUNT cycles
//                of holding, and every 2**LOG_REPEAT_COUNT cycles after that
//                (unless repeat is disabled for the channel).
//  Ports       : clk_in    system clock
//                rst_n_in  synchronous active-low reset
//                bus       btn_repeat_array_if.slave (inputs and strobes)
//  Revision    : 1.0  initial release
// ============================================================================
module btn_repeat_array #(
   parameter int NUM_CH             = 5,
   parameter int LOG_DEBOUNCE_COUNT = 20,
   parameter int LOG_DELAY_COUNT    = 26,
   parameter int LOG_REPEAT_COUNT   = 22
) (
   input wire logic        clk_in,
   input wire logic        rst_n_in,
   btn_repeat_array_if.slave bus
);

   // Shared delay/repeat timer width.
   localparam int c_CW = (LOG_DELAY_COUNT > LOG_REPEAT_COUNT) ?
                         LOG_DELAY_COUNT : LOG_REPEAT_COUNT;

   // Terminal timer values D-1 and R-1 (all-ones of the respective width).
   localparam logic [c_CW-1:0] c_D_LAST = c_CW'({LOG_DELAY_COUNT{1'b1}});
   localparam logic [c_CW-1:0] c_R_LAST = c_CW'({LOG_REPEAT_COUNT{1'b1}});

   localparam logic [1:0] c_S_IDLE   = 2'd0;
   localparam logic [1:0] c_S_DELAY  = 2'd1;
   localparam logic [1:0] c_S_REPEAT = 2'd2;
   localparam logic [1:0] c_S_HOLD   = 2'd3;

   logic [NUM_CH-1:0] w_clean;
   logic [NUM_CH-1:0] w_press;
   logic [NUM_CH-1:0] w_release;
   logic [NUM_CH-1:0] w_move;
   logic [NUM_CH-1:0] w_long;
   logic [NUM_CH-1:0] w_move_d;
   logic              any_move_q;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic                          sample_q;
      logic                          clean_q;
      logic                          prev_q;
      logic [LOG_DEBOUNCE_COUNT-1:0] cnt_q;
      logic [1:0]                    state_q, state_d;
      logic [c_CW-1:0]               tmr_q, tmr_d;
      logic                          press_q, press_d;
      logic                          release_q, release_d;
      logic                          move_q, move_d;
      logic                          long_q, long_d;
      logic                          w_rise, w_fall, w_expire;

      // ---------------- debounce + edge history ----------------
      // Any change of the raw level restarts the window; the clean level
      // is only updated once the sample has been stable for the full window.
      always_ff @(posedge clk_in) begin
         if (!rst_n_in) begin
            sample_q <= bus.noisy_in[gi];
            clean_q  <= bus.noisy_in[gi];
            prev_q   <= bus.noisy_in[gi];
            cnt_q    <= '0;
         end else begin
            prev_q <= clean_q;
            if (bus.noisy_in[gi] != sample_q) begin
               sample_q <= bus.noisy_in[gi];
               cnt_q    <= '0;
            end else if (cnt_q == {LOG_DEBOUNCE_COUNT{1'b1}}) begin
               clean_q <= sample_q;
            end else begin
               cnt_q <= cnt_q + LOG_DEBOUNCE_COUNT'(1);
            end
         end
      end

      assign w_rise = clean_q & ~prev_q;
      assign w_fall = ~clean_q & prev_q;

      // Terminal count of whichever interval the FSM is currently timing.
      assign w_expire = (state_q == c_S_DELAY)  ? (tmr_q == c_D_LAST) :
                        (state_q == c_S_REPEAT) ? (tmr_q == c_R_LAST) : 1'b0;

      // ---------------- FSM state + registered outputs ----------------
      always_ff @(posedge clk_in) begin
         if (!rst_n_in) begin
            state_q   <= c_S_IDLE;
            tmr_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            move_q    <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            press_q   <= press_d;
            release_q <= release_d;
            move_q    <= move_d;
            long_q    <= long_d;
         end
      end

      // ---------------- next-state ----------------
      // A release always wins over a coincident delay expiry or repeat tick.
      always_comb begin
         state_d = state_q;
         tmr_d   = tmr_q;
         case (state_q)
            c_S_IDLE: begin
               if (w_rise) begin
                  state_d = c_S_DELAY;
                  tmr_d   = '0;
               end
            end
            c_S_DELAY, c_S_REPEAT: begin
               if (w_fall) begin
                  state_d = c_S_IDLE;
                  tmr_d   = '0;
               end else if (w_expire) begin
                  state_d = bus.repeat_en_in[gi] ? c_S_REPEAT : c_S_HOLD;
                  tmr_d   = '0;
               end else begin
                  tmr_d = tmr_q + c_CW'(1);
               end
            end
            c_S_HOLD: begin
               if (w_fall) begin
                  state_d = c_S_IDLE;
                  tmr_d   = '0;
               end
            end
            default: begin
               state_d = c_S_IDLE;
               tmr_d   = '0;
            end
         endcase
      end

      // ---------------- outputs ----------------
      // Release follows the debounced falling edge in every state, so a
      // button held through reset still reports its release.
      always_comb begin
         press_d   = (state_q == c_S_IDLE) && w_rise;
         release_d = w_fall;
         move_d    = press_d ||
                     ((state_q != c_S_IDLE) && !w_fall && w_expire &&
                      bus.repeat_en_in[gi]);
         long_d    = long_q;
         if (w_fall) begin
            long_d = 1'b0;
         end else if ((state_q == c_S_DELAY) && w_expire) begin
            long_d = 1'b1;
         end
      end

      assign w_clean[gi]   = clean_q;
      assign w_press[gi]   = press_q;
      assign w_release[gi] = release_q;
      assign w_move[gi]    = move_q;
      assign w_long[gi]    = long_q;
      assign w_move_d[gi]  = move_d;
   end

   // Registered from the next-state moves so it lines up with move_out.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         any_move_q <= 1'b0;
      end else begin
         any_move_q <= |w_move_d;
      end
   end

   assign bus.clean_out    = w_clean;
   assign bus.press_out    = w_press;
   assign bus.release_out  = w_release;
   assign bus.move_out     = w_move;
   assign bus.long_out     = w_long;
   assign bus.any_move_out = any_move_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_repeat_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_repeat_array
//  Description : Directed bench for btn_repeat_array with DB=4, D=8, R=4.
//                Cycle k of a scenario is the state just after the k-th
//                clock edge of that scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_repeat_array;

   localparam int NUM_CH = 5;

   logic clk_in;
   logic rst_n_in;
   int   n_pass;
   int   n_total;

   btn_repeat_array_if #(.NUM_CH(NUM_CH)) bus ();

   btn_repeat_array #(
      .NUM_CH            (NUM_CH),
      .LOG_DEBOUNCE_COUNT(2),
      .LOG_DELAY_COUNT   (3),
      .LOG_REPEAT_COUNT  (2)
   ) dut (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .bus     (bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Advance one edge; outputs are then stable for sampling.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      logic [5:0] got;
      rst_n_in = 1'b0;
      bus.noisy_in = '0;
      bus.repeat_en_in = '1;
      for (int i = 0; i < 3; i++) tick();
      n_total++;
      if (bus.clean_out !== 5'b00000) $display("FAIL reset_clean got=%b exp=00000", bus.clean_out);
      else n_pass++;
      got = {bus.press_out[0], bus.release_out[0], bus.move_out[0], bus.long_out[0],
             bus.any_move_out, 1'b0};
      n_total++;
      if ((bus.press_out | bus.release_out | bus.move_out | bus.long_out) !== 5'b00000 ||
          bus.any_move_out !== 1'b0)
         $display("FAIL reset_strobes got=%b/%b/%b/%b/%b exp=all zero", bus.press_out,
                  bus.release_out, bus.move_out, bus.long_out, bus.any_move_out);
      else n_pass++;
      if (got[0] !== 1'b0) $display("unexpected");
      rst_n_in = 1'b1;
   endtask

   task automatic test_clean_press();
      logic [5:0] exp, got;
      logic       mv;
      for (int k = 1; k <= 40; k++) begin
         bus.noisy_in[0] = (k < 31);
         tick();
         mv  = (k == 6) || (k >= 14 && k < 36 && ((k - 14) % 4) == 0);
         exp = {(k >= 5 && k < 35), (k == 6), (k == 36), mv, (k >= 14 && k < 36), mv};
         got = {bus.clean_out[0], bus.press_out[0], bus.release_out[0], bus.move_out[0],
                bus.long_out[0], bus.any_move_out};
         n_total++;
         if (got !== exp) $display("FAIL clean_press k=%0d got=%b exp=%b", k, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_glitch();
      logic [5:0] exp, got;
      logic       mv;
      for (int k = 1; k <= 30; k++) begin
         bus.noisy_in[1] = (k <= 3) || (k >= 5 && k <= 20);
         tick();
         mv  = (k == 10) || (k == 18) || (k == 22);
         exp = {(k >= 9 && k < 25), (k == 10), (k == 26), mv, (k >= 18 && k < 26), mv};
         got = {bus.clean_out[1], bus.press_out[1], bus.release_out[1], bus.move_out[1],
                bus.long_out[1], bus.any_move_out};
         n_total++;
         if (got !== exp) $display("FAIL glitch k=%0d got=%b exp=%b", k, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_repeat_disable();
      logic [5:0] exp, got;
      logic       mv;
      for (int k = 1; k <= 40; k++) begin
         bus.noisy_in[1]     = (k <= 30);
         bus.repeat_en_in[1] = (k < 20) || (k >= 24);
         tick();
         mv  = (k == 6) || (k == 14) || (k == 18);
         exp = {(k >= 5 && k < 35), (k == 6), (k == 36), mv, (k >= 14 && k < 36), mv};
         got = {bus.clean_out[1], bus.press_out[1], bus.release_out[1], bus.move_out[1],
                bus.long_out[1], bus.any_move_out};
         n_total++;
         if (got !== exp) $display("FAIL repeat_disable k=%0d got=%b exp=%b", k, got, exp);
         else n_pass++;
      end
      bus.repeat_en_in[1] = 1'b1;
   endtask

   task automatic test_single_shot();
      logic [5:0] exp, got;
      bus.repeat_en_in[2] = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         bus.noisy_in[2] = (k <= 40);
         tick();
         exp = {(k >= 5 && k < 45), (k == 6), (k == 46), (k == 6), (k >= 14 && k < 46), (k == 6)};
         got = {bus.clean_out[2], bus.press_out[2], bus.release_out[2], bus.move_out[2],
                bus.long_out[2], bus.any_move_out};
         n_total++;
         if (got !== exp) $display("FAIL single_shot k=%0d got=%b exp=%b", k, got, exp);
         else n_pass++;
      end
      bus.repeat_en_in[2] = 1'b1;
   endtask

   // Fall lands on the delay-expiry cycle; a second press proves IDLE again.
   task automatic test_release_at_expiry();
      logic [5:0] exp, got;
      logic       mv;
      for (int k = 1; k <= 33; k++) begin
         bus.noisy_in[3] = (k <= 8) || (k >= 21 && k <= 25);
         tick();
         mv  = (k == 6) || (k == 26);
         exp = {((k >= 5 && k < 13) || (k >= 25 && k < 30)), mv, (k == 14 || k == 31),
                mv, 1'b0, mv};
         got = {bus.clean_out[3], bus.press_out[3], bus.release_out[3], bus.move_out[3],
                bus.long_out[3], bus.any_move_out};
         n_total++;
         if (got !== exp) $display("FAIL release_at_expiry k=%0d got=%b exp=%b", k, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_reset_held();
      logic [4:0] strobes;
      logic [5:0] exp, got;
      bus.noisy_in[4] = 1'b1;
      rst_n_in = 1'b0;
      for (int r = 1; r <= 3; r++) begin
         tick();
         strobes = bus.press_out | bus.release_out | bus.move_out | bus.long_out;
         n_total++;
         if (bus.clean_out !== 5'b10000 || strobes !== 5'b00000 || bus.any_move_out !== 1'b0)
            $display("FAIL reset_held_in_reset r=%0d got clean=%b strobes=%b any=%b exp clean=10000 strobes=00000 any=0",
                     r, bus.clean_out, strobes, bus.any_move_out);
         else n_pass++;
      end
      rst_n_in = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         bus.noisy_in[4] = (k <= 6);
         tick();
         exp = {(k < 11), 1'b0, (k == 12), 1'b0, 1'b0, 1'b0};
         got = {bus.clean_out[4], bus.press_out[4], bus.release_out[4], bus.move_out[4],
                bus.long_out[4], bus.any_move_out};
         n_total++;
         if (got !== exp) $display("FAIL reset_held k=%0d got=%b exp=%b", k, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_concurrency();
      logic [4:0] exp0, got0, exp4, got4;
      logic       mv0, mv4;
      bus.repeat_en_in[0] = 1'b1;
      bus.repeat_en_in[4] = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         bus.noisy_in[0] = (k <= 20);
         bus.noisy_in[4] = (k <= 20);
         tick();
         mv0  = (k == 6) || (k == 14) || (k == 18) || (k == 22);
         mv4  = (k == 6);
         exp0 = {(k >= 5 && k < 25), (k == 6), (k == 26), mv0, (k >= 14 && k < 26)};
         exp4 = {(k >= 5 && k < 25), (k == 6), (k == 26), mv4, (k >= 14 && k < 26)};
         got0 = {bus.clean_out[0], bus.press_out[0], bus.release_out[0], bus.move_out[0],
                 bus.long_out[0]};
         got4 = {bus.clean_out[4], bus.press_out[4], bus.release_out[4], bus.move_out[4],
                 bus.long_out[4]};
         n_total++;
         if (got0 !== exp0) $display("FAIL concurrency_ch0 k=%0d got=%b exp=%b", k, got0, exp0);
         else n_pass++;
         n_total++;
         if (got4 !== exp4) $display("FAIL concurrency_ch4 k=%0d got=%b exp=%b", k, got4, exp4);
         else n_pass++;
         n_total++;
         if (bus.any_move_out !== (mv0 | mv4))
            $display("FAIL concurrency_any k=%0d got=%b exp=%b", k, bus.any_move_out, mv0 | mv4);
         else n_pass++;
      end
      bus.repeat_en_in[4] = 1'b1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_clean_press();
      test_glitch();
      test_repeat_disable();
      test_single_shot();
      test_release_at_expiry();
      test_reset_held();
      test_concurrency();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/btn_repeat_array.md
Name: btn_repeat_array

Overview:
- Parametrised successor to the per-button debounce plus press-wait-hold logic in the board UI.
- Conditions NUM_CH raw button/switch inputs with a debouncer per channel.
- Each channel produces press, release and move strobes, with a programmable initial delay and a periodic auto-repeat rate.
- Each channel can disable auto-repeat individually (single-shot mode). Feeds the cursor/viewport logic and the speed/click controls.

Parameters:
- NUM_CH, 5, number of independent channels.
- LOG_DEBOUNCE_COUNT, 20, debounce window DB = 2**LOG_DEBOUNCE_COUNT cycles.
- LOG_DELAY_COUNT, 26, initial hold delay D = 2**LOG_DELAY_COUNT cycles before the first repeat.
- LOG_REPEAT_COUNT, 22, repeat period R = 2**LOG_REPEAT_COUNT cycles between repeats.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  synchronous active-low reset.
- noisy_in  input  NUM_CH  raw button levels, asynchronous to the block's timing.
- repeat_en_in  input  NUM_CH  per-channel auto-repeat enable; 0 selects single-shot mode.
- clean_out  output  NUM_CH  debounced levels.
- press_out  output  NUM_CH  1-cycle strobe on a debounced rising edge.
- release_out  output  NUM_CH  1-cycle strobe on a debounced falling edge.
- move_out  output  NUM_CH  1-cycle strobe: on the initial press and on each repeat.
- long_out  output  NUM_CH  level, high while the button is held past D.
- any_move_out  output  1  OR of move_out.

Behaviour:
- Design: one clock, synchronous active-low reset. All outputs are registered. Channels are fully independent; there is no priority between channels.
- Reset (rst_n_in=0 at an edge), per channel:
  - sample register <= noisy_in; clean_out <= noisy_in; debounce count <= 0.
  - prev-clean register <= noisy_in, so a button held through reset produces no press.
  - FSM <= IDLE; delay/repeat counter <= 0.
  - press_out, release_out, move_out, long_out, any_move_out <= 0.
  - Reset mid-operation aborts all strobes and repeats immediately.
- Debounce, per channel, at each edge:
  - If noisy != sample: sample <= noisy, count <= 0.
  - Else if count == DB-1: clean <= sample, count holds.
  - Else count <= count+1.
  - A new level first sampled at edge t appears on clean_out after edge t+DB.
  - Any glitch shorter than DB restarts the window.
- Edge detect: rise = clean & ~prev_clean; fall = ~clean & prev_clean; prev_clean <= clean every cycle. Strobes appear one cycle after clean_out changes.
- FSM per channel, with states IDLE, DELAY, REPEAT, HOLD. Counter width is max(LOG_DELAY_COUNT, LOG_REPEAT_COUNT). Let P be the cycle press_out is high.
  - IDLE: on rise, press_out=1, move_out=1, counter <= 0, go DELAY.
  - DELAY: counter increments each cycle. When counter == D-1 (expiry):
    - long_out <= 1.
    - If repeat_en_in=1 (sampled on the expiry cycle): move_out=1, counter <= 0, go REPEAT.
    - Otherwise go HOLD with no move.
  - REPEAT: counter increments; at counter == R-1, move_out=1 and counter <= 0.
  - HOLD: no strobes; wait for release.
  - Any non-IDLE state: on fall, release_out=1, long_out <= 0, counter <= 0, go IDLE, and no move_out that cycle. Fall takes precedence over a coincident expiry or repeat.
- move_out timing: high in cycles P, P+D, P+D+R, P+D+2R, ... while held.
- repeat_en_in:
  - Deasserting it while in REPEAT stops further moves; go HOLD at the next would-be repeat instant.
  - Reasserting it in HOLD has no effect until the next press.
- Counters never wrap into spurious events: a counter is cleared on every state entry.
- press_out and release_out are never high in the same cycle for one channel. The minimum spacing between them is DB+1 cycles.

Test Plan (LOG_DEBOUNCE_COUNT=2 so DB=4; LOG_DELAY_COUNT=3 so D=8; LOG_REPEAT_COUNT=2 so R=4; NUM_CH=5):
- Clean press, single channel: ch0 noisy rises at edge 10 and stays high → clean_out[0] high after edge 14, press_out[0] and move_out[0] high in cycle 15 only. Then move_out[0] high in cycles 23, 27, 31; long_out[0] rises with the cycle-23 move.
- Glitch rejection: ch1 high for 3 cycles, low 1 cycle, then high steady from edge 20 → no strobe before edge 24; press_out[1] high once in cycle 25.
- Single-shot mode: repeat_en_in[2]=0, hold ch2 for 40 cycles → exactly one move_out[2] (the press cycle); long_out[2]=1 from P+8 until release; release_out[2] pulses once.
- Release at expiry: release ch3 so that its fall is detected in cycle P+8 → release_out[3]=1, move_out[3]=0, long_out[3] stays 0, FSM returns to IDLE.
- Reset while held: hold ch4 with rst_n_in=0 for 3 cycles, then rst_n_in=1 with ch4 still high → clean_out[4]=1 immediately after reset, no press or move. Releasing ch4 then gives clean_out[4]=0 after 4 cycles and a release_out[4] pulse.
- Concurrency: ch0 and ch4 pressed on the same edge, ch0 repeat enabled → strobes on both in the same cycle; any_move_out=1 in every cycle in which either channel moves.
